// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared definitions for the instruction memory loader:
//   - loader_state_e : loader FSM state encoding
//   - INSTR_BYTES    : bytes per instruction (24-bit instructions)
//   - CNT_W          : width of the frame byte counter (3 * 65535 fits)
//   - chk_fold()     : running XOR checksum step
//   - frame_bytes()  : number of data bytes carried by an N-instruction frame
// -----------------------------------------------------------------------------
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5
    } loader_state_e;

    localparam int unsigned INSTR_BYTES = 32'd3;
    localparam int unsigned CNT_W       = 32'd18;

    // One step of the byte-wise XOR checksum over the data bytes
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // Data bytes in a frame announcing n instructions
    function automatic logic [CNT_W-1:0] frame_bytes(input logic [15:0] n);
        return CNT_W'(n) * CNT_W'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/instr_mem_loader_adder.sv
// -----------------------------------------------------------------------------
// RippleCarryAdder
// Plain ripple-carry adder shared with the fetch-side address math.
// Result is modulo 2^WIDTH; the carry out of the top bit is discarded.
// Ports:
//   a, b : WIDTH-bit operands
//   cin  : carry in
//   sum  : WIDTH-bit result
// -----------------------------------------------------------------------------
module RippleCarryAdder #(
    parameter int unsigned WIDTH = 32'd24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] carry_s;

    // Carry chain from bit 0 upward, then per-bit sum
    always_comb begin
        carry_s    = {WIDTH{1'b0}};
        sum        = {WIDTH{1'b0}};
        carry_s[0] = cin;
        for (int i = 1; i < int'(WIDTH); i++) begin
            carry_s[i] = (a[i-1] & b[i-1]) | (carry_s[i-1] & (a[i-1] ^ b[i-1]));
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i] = a[i] ^ b[i] ^ carry_s[i];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Receives a framed byte stream and writes 24-bit instructions into the
// byte-addressed instruction memory, MSB byte first (A, A+1, A+2), holding the
// CPU in reset while a load session is active.
// Frame: LEN_HI, LEN_LO (instruction count N, big-endian), then 3*N data bytes.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing checksum byte that
// must equal the XOR of all data bytes.
// Ports:
//   Clock   : system clock, rising edge
//   Reset   : synchronous, active-high
//   Start   : pulse, begins a session (honoured in IDLE/DONE only)
//   InData  : stream byte
//   InValid : InData valid
//   InReady : loader accepts a byte this cycle
//   WrEn    : memory byte write strobe (one cycle after the byte transfer)
//   WrAddr  : memory byte address
//   WrData  : memory byte data
//   CpuHold : high while a session is in progress
//   Done    : high in DONE
//   Error   : sticky per session (overflow, checksum mismatch)
// -----------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 32'd128,
    parameter int unsigned ADDR_W    = 32'd24,
    parameter int unsigned BASE_ADDR = 32'd0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        InData,
    input  logic              InValid,
    output logic              InReady,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [7:0]        WrData,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LIMIT_C = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ONE_C   = {{(ADDR_W-1){1'b0}}, 1'b1};

    loader_state_e      state_r;
    logic               in_ready_r;
    logic               wr_en_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [7:0]         wr_data_r;
    logic               cpu_hold_r;
    logic               done_r;
    logic               error_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [7:0]         len_hi_r;
    logic [CNT_W-1:0]   total_r;
    logic [CNT_W-1:0]   cnt_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         chk_r;
`endif

    logic               xfer_s;
    logic [15:0]        len_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [ADDR_W-1:0]  addr_inc_s;
    logic               in_range_s;

    assign xfer_s     = InValid & in_ready_r;
    assign len_s      = {len_hi_r, InData};
    assign cnt_next_s = cnt_r + 18'd1;
    // Bytes past the end of memory are consumed but never written
    assign in_range_s = (addr_r < LIMIT_C);

    RippleCarryAdder #(
        .WIDTH (ADDR_W)
    ) u_addr_inc (
        .a   (addr_r),
        .b   (ONE_C),
        .cin (1'b0),
        .sum (addr_inc_s)
    );

    // Loader FSM with datapath registers and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= BASE_C;
            wr_data_r  <= 8'h00;
            cpu_hold_r <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            addr_r     <= BASE_C;
            len_hi_r   <= 8'h00;
            total_r    <= 18'd0;
            cnt_r      <= 18'd0;
`ifdef LOADER_CHECKSUM_EN
            chk_r      <= 8'h00;
`endif
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        state_r    <= ST_LEN_HI;
                        in_ready_r <= 1'b1;
                        cpu_hold_r <= 1'b1;
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                        addr_r     <= BASE_C;
                        wr_addr_r  <= BASE_C;
                        cnt_r      <= 18'd0;
`ifdef LOADER_CHECKSUM_EN
                        chk_r      <= 8'h00;
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer_s) begin
                        len_hi_r <= InData;
                        state_r  <= ST_LEN_LO;
                    end else begin
                        state_r <= ST_LEN_HI;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer_s) begin
                        total_r <= frame_bytes(len_s);
                        if (len_s != 16'd0) begin
                            state_r <= ST_DATA;
                        end else begin
`ifdef LOADER_CHECKSUM_EN
                            state_r    <= ST_CHK;
`else
                            state_r    <= ST_DONE;
                            in_ready_r <= 1'b0;
                            cpu_hold_r <= 1'b0;
                            done_r     <= 1'b1;
`endif
                        end
                    end else begin
                        state_r <= ST_LEN_LO;
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        cnt_r  <= cnt_next_s;
                        addr_r <= addr_inc_s;
`ifdef LOADER_CHECKSUM_EN
                        chk_r  <= chk_fold(chk_r, InData);
`endif
                        if (in_range_s) begin
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= addr_r;
                            wr_data_r <= InData;
                        end else begin
                            error_r <= 1'b1;
                        end
                        if (cnt_next_s == total_r) begin
`ifdef LOADER_CHECKSUM_EN
                            state_r    <= ST_CHK;
`else
                            state_r    <= ST_DONE;
                            in_ready_r <= 1'b0;
                            cpu_hold_r <= 1'b0;
                            done_r     <= 1'b1;
`endif
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer_s) begin
                        if (InData != chk_r) begin
                            error_r <= 1'b1;
                        end else begin
                            error_r <= error_r;
                        end
                        state_r    <= ST_DONE;
                        in_ready_r <= 1'b0;
                        cpu_hold_r <= 1'b0;
                        done_r     <= 1'b1;
                    end else begin
                        state_r <= ST_CHK;
                    end
                end
`endif
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    cpu_hold_r <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign InReady = in_ready_r;
    assign WrEn    = wr_en_r;
    assign WrAddr  = wr_addr_r;
    assign WrData  = wr_data_r;
    assign CpuHold = cpu_hold_r;
    assign Done    = done_r;
    assign Error   = error_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
// Directed, table-driven bench for instr_mem_loader (MEM_DEPTH=128, ADDR_W=24,
// BASE_ADDR=0). Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  InData;
    logic        InValid;
    logic        InReady;
    logic        WrEn;
    logic [23:0] WrAddr;
    logic [7:0]  WrData;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        ir;
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wd;
        logic        hold;
        logic        done;
        logic        err;
    } vec_t;

    vec_t       tbl[10];
    logic [7:0] frame_b[8];

    instr_mem_loader #(
        .MEM_DEPTH (128),
        .ADDR_W    (24),
        .BASE_ADDR (0)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .InData  (InData),
        .InValid (InValid),
        .InReady (InReady),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .CpuHold (CpuHold),
        .Done    (Done),
        .Error   (Error)
    );

    // Free-running 10-unit clock
    always #5 Clock = ~Clock;

    task automatic cycle(input logic s, input logic v, input logic [7:0] d);
        Start   = s;
        InValid = v;
        InData  = d;
        @(posedge Clock);
        #1;
        Start   = 1'b0;
        InValid = 1'b0;
    endtask

    task automatic check_out(input string name, input logic ir, input logic we,
                             input logic [23:0] a, input logic [7:0] wd,
                             input logic h, input logic dn, input logic er);
        logic [36:0] act;
        logic [36:0] exp;
        act = {InReady, WrEn, WrAddr, WrData, CpuHold, Done, Error};
        exp = {ir, we, a, wd, h, dn, er};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual {InReady,WrEn,WrAddr,WrData,CpuHold,Done,Error}=%h required=%h",
                     name, act, exp);
        end
    endtask

    initial begin
        logic        last;
        logic        we;
        logic [23:0] a;
        logic [7:0]  wd;

        Reset   = 1'b1;
        Start   = 1'b0;
        InValid = 1'b0;
        InData  = 8'h00;

        // start, valid, data | InReady, WrEn, WrAddr, WrData, CpuHold, Done, Error
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 24'd0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 24'd0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 24'd0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 24'd0, 8'hAA, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'hBB, 1'b1, 1'b1, 24'd1, 8'hBB, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'hCC, 1'b1, 1'b1, 24'd2, 8'hCC, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 24'd3, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 24'd4, 8'h22, 1'b1, 1'b0, 1'b0};
`ifdef LOADER_CHECKSUM_EN
        tbl[8] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 24'd5, 8'h33, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 8'hDD, 1'b0, 1'b0, 24'd5, 8'h33, 1'b0, 1'b1, 1'b0};
`else
        tbl[8] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 24'd5, 8'h33, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 24'd5, 8'h33, 1'b0, 1'b1, 1'b0};
`endif
        frame_b = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};

        // Reset state
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check_out("reset", 1'b0, 1'b0, 24'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;

        // Basic frame, including an ignored Start mid-session and a byte offered in DONE
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].start, tbl[i].valid, tbl[i].data);
            check_out($sformatf("table[%0d]", i), tbl[i].ir, tbl[i].we, tbl[i].addr,
                      tbl[i].wd, tbl[i].hold, tbl[i].done, tbl[i].err);
        end

        // Same frame restarted from DONE, InValid toggling every other cycle
        cycle(1'b1, 1'b0, 8'h00);
        check_out("gap_start", 1'b1, 1'b0, 24'd0, 8'h33, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            last = (i == 7);
            we   = (i >= 2);
            a    = (i >= 2) ? 24'(i - 2) : 24'd0;
            wd   = (i >= 2) ? frame_b[i] : 8'h33;
            cycle(1'b0, 1'b1, frame_b[i]);
            check_out($sformatf("gap_xfer[%0d]", i), last ? CHK : 1'b1, we, a, wd,
                      last ? CHK : 1'b1, last & ~CHK, 1'b0);
            cycle(1'b0, 1'b0, 8'hFF);
            check_out($sformatf("gap_idle[%0d]", i), last ? CHK : 1'b1, 1'b0, a, wd,
                      last ? CHK : 1'b1, last & ~CHK, 1'b0);
        end
`ifdef LOADER_CHECKSUM_EN
        cycle(1'b0, 1'b1, 8'hDD);
        check_out("gap_chk", 1'b0, 1'b0, 24'd5, 8'h33, 1'b0, 1'b1, 1'b0);
`endif

        // Zero-length frame
        cycle(1'b1, 1'b0, 8'h00);
        check_out("zero_start", 1'b1, 1'b0, 24'd0, 8'h33, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00);
        check_out("zero_lenhi", 1'b1, 1'b0, 24'd0, 8'h33, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00);
        check_out("zero_lenlo", CHK, 1'b0, 24'd0, 8'h33, CHK, ~CHK, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        cycle(1'b0, 1'b1, 8'h00);
        check_out("zero_chk", 1'b0, 1'b0, 24'd0, 8'h33, 1'b0, 1'b1, 1'b0);
`endif
        cycle(1'b0, 1'b0, 8'h00);
        check_out("zero_idle", 1'b0, 1'b0, 24'd0, 8'h33, 1'b0, 1'b1, 1'b0);

        // Overflow: N=43 -> 129 bytes, last one lands at address 128
        cycle(1'b1, 1'b0, 8'h00);
        check_out("ovf_start", 1'b1, 1'b0, 24'd0, 8'h33, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h2B);
        check_out("ovf_len", 1'b1, 1'b0, 24'd0, 8'h33, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= 128; i++) begin
            last = (i == 128);
            cycle(1'b0, 1'b1, 8'(i));
            check_out($sformatf("ovf[%0d]", i), last ? CHK : 1'b1, (i < 128),
                      (i < 128) ? 24'(i) : 24'd127, (i < 128) ? 8'(i) : 8'h7F,
                      last ? CHK : 1'b1, last & ~CHK, last);
        end
`ifdef LOADER_CHECKSUM_EN
        cycle(1'b0, 1'b1, 8'h80);
        check_out("ovf_chk", 1'b0, 1'b0, 24'd127, 8'h7F, 1'b0, 1'b1, 1'b1);
`endif

        // Reset after the 4th data byte, then a fresh session from address 0
        cycle(1'b1, 1'b0, 8'h00);
        check_out("rst_start", 1'b1, 1'b0, 24'd0, 8'h7F, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h02);
        cycle(1'b0, 1'b1, 8'hAA);
        cycle(1'b0, 1'b1, 8'hBB);
        cycle(1'b0, 1'b1, 8'hCC);
        cycle(1'b0, 1'b1, 8'h11);
        check_out("rst_4th", 1'b1, 1'b1, 24'd3, 8'h11, 1'b1, 1'b0, 1'b0);
        Reset = 1'b1;
        cycle(1'b0, 1'b1, 8'h22);
        Reset = 1'b0;
        check_out("rst_hit", 1'b0, 1'b0, 24'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 8'h55);
            check_out($sformatf("rst_idle[%0d]", i), 1'b0, 1'b0, 24'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 8'h00);
        check_out("reload_start", 1'b1, 1'b0, 24'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h01);
        check_out("reload_len", 1'b1, 1'b0, 24'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h5A);
        check_out("reload_b0", 1'b1, 1'b1, 24'd0, 8'h5A, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h6B);
        check_out("reload_b1", 1'b1, 1'b1, 24'd1, 8'h6B, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h7C);
        check_out("reload_b2", CHK, 1'b1, 24'd2, 8'h7C, CHK, ~CHK, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        cycle(1'b0, 1'b1, 8'h4D);
        check_out("reload_chk", 1'b0, 1'b0, 24'd2, 8'h7C, 1'b0, 1'b1, 1'b0);

        // Checksum good (07) and bad (06) on frame 00 01 01 02 04
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, 8'h00);
            cycle(1'b0, 1'b1, 8'h00);
            cycle(1'b0, 1'b1, 8'h01);
            cycle(1'b0, 1'b1, 8'h01);
            cycle(1'b0, 1'b1, 8'h02);
            cycle(1'b0, 1'b1, 8'h04);
            check_out($sformatf("cs_data[%0d]", k), 1'b1, 1'b1, 24'd2, 8'h04, 1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, (k == 0) ? 8'h07 : 8'h06);
            check_out($sformatf("cs_end[%0d]", k), 1'b0, 1'b0, 24'd2, 8'h04, 1'b0, 1'b1, (k != 0));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
